// File: rtl/tt_arith_pkg.sv
// Shared types and defaults for the TinyTapeout arithmetic unit.
// Op codes match the two-bit encoding on the wrapper pins.
package tt_arith_pkg;

  localparam int TT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

endpackage

// File: rtl/tt_addsub_sat.sv
// Combinational W+1-bit add/subtract with carry/borrow out and optional clamp.
// carry always reflects the unclamped operation.
module tt_addsub_sat #(
  parameter int W        = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] res,
  output logic         carry
);

  logic [W:0] sum;

  always_comb begin
    if (sub) begin
      sum = {1'b0, x} - {1'b0, y};
    end else begin
      sum = {1'b0, x} + {1'b0, y};
    end
    carry = sum[W];
    res   = sum[W-1:0];
    // Overflow clamps high, borrow clamps low.
    if (SATURATE && sum[W]) begin
      res = sub ? '0 : '1;
    end
  end

endmodule

// File: rtl/tt_arith_unit.sv
// Registered add/sub/accumulate/load unit with a one-deep output register.
// Accumulator only moves on an accepted ACC or LOAD.
module tt_arith_unit
  import tt_arith_pkg::*;
#(
  parameter int W        = TT_W_DEFAULT,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic [W-1:0] acc
);

  // Handshake: a transfer happens on a cycle where valid and ready are both 1.
  // The producer holds its payload stable while valid=1 and ready=0; ready may
  // depend combinationally on the consumer's ready (in_ready follows out_ready).

  op_e         op_sel;
  logic        accept;
  logic [W-1:0] as_y;
  logic [W-1:0] as_res;
  logic         as_carry;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] result_q, result_d;
  logic         carry_q, carry_d;
  logic [W-1:0] acc_q, acc_d;

  assign op_sel   = op_e'(op);
  assign in_ready = ena & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // ACC adds the operand to the accumulator; b is only used by ADD/SUB.
  assign as_y = (op_sel == OP_ACC) ? acc_q : b;

  tt_addsub_sat #(
    .W        (W),
    .SATURATE (SATURATE)
  ) u_addsub (
    .x     (a),
    .y     (as_y),
    .sub   (op_sel == OP_SUB),
    .res   (as_res),
    .carry (as_carry)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      unique case (op_sel)
        OP_LOAD: begin
          result_d = a;
          carry_d  = 1'b0;
          acc_d    = a;
        end
        OP_ACC: begin
          result_d = as_res;
          carry_d  = as_carry;
          acc_d    = as_res;
        end
        default: begin
          result_d = as_res;
          carry_d  = as_carry;
        end
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_tt_arith_unit.sv
// Bench for tt_arith_unit: a wrapping and a saturating instance share stimulus
// and are compared against an integer reference model.
module tb_tt_arith_unit;
  import tt_arith_pkg::*;

  localparam int W  = 8;
  localparam int EW = 2 * (W + 1) + 2 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         ir_w, ov_w, c_w, ir_s, ov_s, c_s;
  logic [W-1:0] r_w, acc_w, r_s, acc_s;

  int n_checks = 0;
  int n_err    = 0;
  int m_acc_w  = 0;
  int m_acc_s  = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp = '0;

  tt_arith_unit #(.W(W), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(ir_w),
    .op(op), .a(a), .b(b), .out_valid(ov_w), .out_ready(out_ready),
    .result(r_w), .carry(c_w), .acc(acc_w)
  );

  tt_arith_unit #(.W(W), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(ir_s),
    .op(op), .a(a), .b(b), .out_valid(ov_s), .out_ready(out_ready),
    .result(r_s), .carry(c_s), .acc(acc_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: wrap means subtract/add 2^W, saturate means clamp.
  function automatic void ref_op(input int o, input int x, input int y, input bit sat,
                                 inout int acc_m, output int r, output int c);
    int s;
    int top;
    top = (1 << W) - 1;
    case (o)
      0: begin
        s = x + y;
        c = (s > top) ? 1 : 0;
        r = (c == 1) ? (sat ? top : s - (top + 1)) : s;
      end
      1: begin
        s = x - y;
        c = (x < y) ? 1 : 0;
        r = (c == 1) ? (sat ? 0 : s + top + 1) : s;
      end
      2: begin
        s = acc_m + x;
        c = (s > top) ? 1 : 0;
        r = (c == 1) ? (sat ? top : s - (top + 1)) : s;
        acc_m = r;
      end
      default: begin
        r = x;
        c = 0;
        acc_m = x;
      end
    endcase
  endfunction

  task automatic predict(input int o, input int x, input int y);
    int rw, cw, rs, cs;
    ref_op(o, x, y, 1'b0, m_acc_w, rw, cw);
    ref_op(o, x, y, 1'b1, m_acc_s, rs, cs);
    exp_q.push_back({1'(cw), W'(rw), 1'(cs), W'(rs), W'(m_acc_w), W'(m_acc_s)});
  endtask

  task automatic check_fields(input string tag, input logic [EW-1:0] e);
    check({tag, "_ov_w"},  32'(ov_w),  32'd1);
    check({tag, "_ov_s"},  32'(ov_s),  32'd1);
    check({tag, "_c_w"},   32'(c_w),   32'(e[EW-1]));
    check({tag, "_r_w"},   32'(r_w),   32'(e[EW-2 -: W]));
    check({tag, "_c_s"},   32'(c_s),   32'(e[EW-2-W]));
    check({tag, "_r_s"},   32'(r_s),   32'(e[EW-3-W -: W]));
    check({tag, "_acc_w"}, 32'(acc_w), 32'(e[2*W-1 -: W]));
    check({tag, "_acc_s"}, 32'(acc_s), 32'(e[W-1:0]));
  endtask

  task automatic check_out(input string tag);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: got empty expected queue expected one entry", tag);
    end else begin
      last_exp = exp_q.pop_front();
      check_fields(tag, last_exp);
    end
  endtask

  // One accepted op with the consumer always ready; called at a negedge.
  task automatic run_op(input op_e o, input int x, input int y, input string tag);
    op = o;
    a = W'(x);
    b = W'(y);
    in_valid = 1'b1;
    out_ready = 1'b1;
    predict(int'(o), x, y);
    #1;
    check({tag, "_in_ready"}, 32'(ir_w & ir_s), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ena = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ov",  32'(ov_w | ov_s), 32'd0);
    check("rst_res", 32'(r_w | r_s), 32'd0);
    check("rst_acc", 32'(acc_w | acc_s), 32'd0);
    check("rst_in_ready", 32'(ir_w & ir_s), 32'd1);

    run_op(OP_ADD, 200, 100, "add_ovf");
    run_op(OP_SUB, 3, 5, "sub_borrow");
    run_op(OP_LOAD, 250, 17, "load");
    run_op(OP_ACC, 10, 99, "acc_ovf");
    run_op(OP_ACC, 1, 0, "acc_after");
    run_op(OP_ADD, 7, 9, "add_plain");

    // Stall with a pending result; the offered op must not be taken.
    out_ready = 1'b0;
    op = OP_SUB;
    a = 8'd50;
    b = 8'd8;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 32'(ir_w | ir_s), 32'd0);
      @(negedge clk);
      check_fields("bp_hold", last_exp);
    end
    out_ready = 1'b1;
    predict(int'(OP_SUB), 50, 8);
    #1;
    check("bp_release_ready", 32'(ir_w & ir_s), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp_release");

    // Disabled: pending result drains, nothing new is accepted.
    out_ready = 1'b0;
    ena = 1'b0;
    op = OP_LOAD;
    a = 8'd99;
    in_valid = 1'b1;
    #1;
    check("ena_in_ready", 32'(ir_w | ir_s), 32'd0);
    repeat (3) @(negedge clk);
    check_fields("ena_hold", last_exp);
    out_ready = 1'b1;
    #1;
    check("ena_drain_ready", 32'(ir_w | ir_s), 32'd0);
    repeat (2) @(negedge clk);
    check("ena_drained_ov", 32'(ov_w | ov_s), 32'd0);
    check("ena_acc_w", 32'(acc_w), 32'(m_acc_w));
    check("ena_acc_s", 32'(acc_s), 32'(m_acc_s));
    in_valid = 1'b0;
    ena = 1'b1;

    // Asynchronous reset with a result pending.
    run_op(OP_LOAD, 77, 0, "pre_rst_load");
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ov",  32'(ov_w | ov_s), 32'd0);
    check("arst_res", 32'(r_w | r_s), 32'd0);
    check("arst_c",   32'(c_w | c_s), 32'd0);
    check("arst_acc", 32'(acc_w | acc_s), 32'd0);
    m_acc_w = 0;
    m_acc_s = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-throughput random stream.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int o, x, y;
      o = int'($urandom_range(0, 3));
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      op = 2'(o);
      a = W'(x);
      b = W'(y);
      in_valid = 1'b1;
      predict(o, x, y);
      #1;
      check("stream_in_ready", 32'(ir_w & ir_s), 32'd1);
      @(negedge clk);
      check_out("stream");
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_end_ov", 32'(ov_w | ov_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
